// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit: single-cycle MULT/MULTU, 32-step restoring DIV/DIVU, MTHI/MTLO.
// Latency: MULT/MTx 1 cycle, DIV 34 cycles; busy stalls issue while a divide runs, flush aborts it.
module hilo_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    DIV_FIX = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic        qsign;
  logic        rsign;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_signed;
  logic        [31:0] dvd_in;
  logic        [31:0] dvs_in;
  logic        [32:0] rem_sh;
  logic        [32:0] trial;
  logic               qbit;
  logic        [31:0] quo_fix;
  logic        [31:0] rem_fix;

  assign busy = (state != IDLE);

  always_comb begin
    prod_s = $signed(a) * $signed(b);
    prod_u = {32'd0, a} * {32'd0, b};
  end

  // A signed divide by zero is run unsigned on raw operands so the
  // natural restoring result (LO all ones, HI = a) comes out unmodified.
  always_comb begin
    div_signed = (op == OP_DIV) && (b != 32'd0);
    dvd_in     = (div_signed && a[31]) ? (32'd0 - a) : a;
    dvs_in     = (div_signed && b[31]) ? (32'd0 - b) : b;
  end

  always_comb begin
    rem_sh  = {rem, quo[31]};
    trial   = rem_sh - {1'b0, dvs};
    qbit    = ~trial[32];
    quo_fix = qsign ? (32'd0 - quo) : quo;
    rem_fix = rsign ? (32'd0 - rem) : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
      quo   <= 32'd0;
      rem   <= 32'd0;
      dvs   <= 32'd0;
      qsign <= 1'b0;
      rsign <= 1'b0;
      hi_o  <= 32'd0;
      lo_o  <= 32'd0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (valid) begin
              case (op)
                OP_MULT: begin
                  hi_o <= prod_s[63:32];
                  lo_o <= prod_s[31:0];
                  done <= 1'b1;
                end
                OP_MULTU: begin
                  hi_o <= prod_u[63:32];
                  lo_o <= prod_u[31:0];
                  done <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                  quo   <= dvd_in;
                  dvs   <= dvs_in;
                  rem   <= 32'd0;
                  qsign <= div_signed & (a[31] ^ b[31]);
                  rsign <= div_signed & a[31];
                  cnt   <= 5'd0;
                  state <= DIV_RUN;
                end
                OP_MTHI: hi_o <= a;
                OP_MTLO: lo_o <= a;
                default: ;
              endcase
            end
          end
          DIV_RUN: begin
            // Dividend bits leave quo's MSB as quotient bits enter its LSB.
            rem <= qbit ? trial[31:0] : rem_sh[31:0];
            quo <= {quo[30:0], qbit};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) state <= DIV_FIX;
          end
          DIV_FIX: begin
            lo_o  <= quo_fix;
            hi_o  <= rem_fix;
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: multiply, divide (signed, unsigned, by zero), flush, reset, MTHI/MTLO.
module tb_hilo_muldiv;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int errors = 0;
  int checks = 0;

  hilo_muldiv dut (
    .clk(clk), .rst(rst), .valid(valid), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    valid = 1'b1; op = o; a = x; b = y;
    step();
    valid = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; flush = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++; if (hi_o !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=%h", hi_o, 32'd0); end
    checks++; if (lo_o !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=%h", lo_o, 32'd0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_mult();
    issue(3'd1, 32'hFFFFFFFF, 32'h00000002);
    checks++; if (hi_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got=%h exp=FFFFFFFF", hi_o); end
    checks++; if (lo_o !== 32'hFFFFFFFE) begin errors++; $display("FAIL mult_lo got=%h exp=FFFFFFFE", lo_o); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mult_done got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy got=%b exp=0", busy); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
    issue(3'd2, 32'hFFFFFFFF, 32'h00000002);
    checks++; if (hi_o !== 32'h00000001) begin errors++; $display("FAIL multu_hi got=%h exp=00000001", hi_o); end
    checks++; if (lo_o !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_lo got=%h exp=FFFFFFFE", lo_o); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL multu_done got=%b exp=1", done); end
    step();
  endtask

  task automatic test_back_to_back();
    valid = 1'b1; op = 3'd1; a = 32'd3; b = 32'hFFFFFFFC;
    step();
    checks++; if (lo_o !== 32'hFFFFFFF4 || hi_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_first got=%h_%h exp=FFFFFFFF_FFFFFFF4", hi_o, lo_o); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1", done); end
    op = 3'd2; a = 32'h00010000; b = 32'h00030000;
    step();
    valid = 1'b0; op = 3'd0;
    checks++; if (lo_o !== 32'd0 || hi_o !== 32'd3) begin errors++; $display("FAIL b2b_second got=%h_%h exp=00000003_00000000", hi_o, lo_o); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b exp=1", done); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_end got=%b exp=0", done); end
  endtask

  // Issue a divide, count busy cycles, then check the landed result.
  task automatic run_div(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi, input string name);
    int n;
    issue(o, x, y);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    checks++; if (n != 33) begin errors++; $display("FAIL %s_busy_cycles got=%0d exp=33", name, n); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_done got=%b exp=1", name, done); end
    checks++; if (lo_o !== exp_lo) begin errors++; $display("FAIL %s_lo got=%h exp=%h", name, lo_o, exp_lo); end
    checks++; if (hi_o !== exp_hi) begin errors++; $display("FAIL %s_hi got=%h exp=%h", name, hi_o, exp_hi); end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got=%b exp=0", name, done); end
  endtask

  task automatic test_div();
    run_div(3'd4, 32'd100, 32'd7, 32'd14, 32'd2, "divu_100_7");
    run_div(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, "div_m7_2");
    run_div(3'd3, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, "div_7_m2");
    run_div(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, "div_min_m1");
    run_div(3'd3, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, "div_by0");
    run_div(3'd4, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, "divu_by0");
  endtask

  task automatic test_flush_abort();
    int dones;
    issue(3'd5, 32'hAAAA0000, 32'd0);
    issue(3'd6, 32'h0000BBBB, 32'd0);
    issue(3'd4, 32'd100, 32'd7);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dones++;
      step();
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL flush_no_done got=%0d exp=0", dones); end
    checks++; if (hi_o !== 32'hAAAA0000 || lo_o !== 32'h0000BBBB) begin errors++; $display("FAIL flush_hilo got=%h_%h exp=AAAA0000_0000BBBB", hi_o, lo_o); end
  endtask

  task automatic test_reset_abort();
    issue(3'd4, 32'd100, 32'd7);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstabort_busy got=%b exp=0", busy); end
    checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin errors++; $display("FAIL rstabort_hilo got=%h_%h exp=0_0", hi_o, lo_o); end
    repeat (30) step();
    checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0 || done !== 1'b0) begin errors++; $display("FAIL rstabort_later got=%h_%h done=%b exp=0_0 done=0", hi_o, lo_o, done); end
  endtask

  task automatic test_mthi_mtlo();
    int n;
    issue(3'd4, 32'd100, 32'd7);
    repeat (3) step();
    issue(3'd5, 32'hDEADBEEF, 32'd0);
    checks++; if (hi_o !== 32'd0 || busy !== 1'b1) begin errors++; $display("FAIL mthi_busy_ignored got=%h busy=%b exp=00000000 busy=1", hi_o, busy); end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    checks++; if (hi_o !== 32'd2 || lo_o !== 32'd14 || done !== 1'b1) begin errors++; $display("FAIL mthi_busy_div got=%h_%h done=%b exp=00000002_0000000E done=1", hi_o, lo_o, done); end
    step();
    issue(3'd5, 32'hDEADBEEF, 32'd0);
    checks++; if (hi_o !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi_idle got=%h exp=DEADBEEF", hi_o); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mthi_no_done got=%b exp=0", done); end
    issue(3'd6, 32'h13579BDF, 32'd0);
    checks++; if (lo_o !== 32'h13579BDF || done !== 1'b0) begin errors++; $display("FAIL mtlo_idle got=%h done=%b exp=13579BDF done=0", lo_o, done); end
    flush = 1'b1;
    issue(3'd6, 32'h55555555, 32'd0);
    flush = 1'b0;
    checks++; if (lo_o !== 32'h13579BDF) begin errors++; $display("FAIL flush_valid_lo got=%h exp=13579BDF", lo_o); end
    flush = 1'b1;
    issue(3'd1, 32'd5, 32'd5);
    flush = 1'b0;
    checks++; if (lo_o !== 32'h13579BDF || done !== 1'b0) begin errors++; $display("FAIL flush_valid_mult got=%h done=%b exp=13579BDF done=0", lo_o, done); end
    issue(3'd7, 32'h11111111, 32'h22222222);
    checks++; if (hi_o !== 32'hDEADBEEF || lo_o !== 32'h13579BDF || done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reserved_op got=%h_%h done=%b busy=%b exp=DEADBEEF_13579BDF done=0 busy=0", hi_o, lo_o, done, busy); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_flush_abort();
    test_reset_abort();
    test_mthi_mtlo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
